instr_reader: RTL and testbench

Sweeps a contiguous, wrap-around range of the 32-entry instruction register through its asynchronous read port. It presents each captured `instruction_t` word on a valid/ready stream toward the scoreboard and monitor. It is the read-side counterpart of the loader that drives `load_en`/`write_pointer`, and it sits beside the instruction register, owning `read_pointer`. Optionally, it recomputes each stored result and flags mismatches.

---
 rtl/instr_reader_if.sv | 57 +++++
 rtl/instr_reader.sv | 176 +++++++++++++++++
 tb/tb_instr_reader.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_reader_if.sv
// instr_reader_pkg / instr_reader_if
// Shared instruction-register types and the valid/ready output stream
// carrying captured words from instr_reader to the scoreboard and monitor.

package instr_reader_pkg;

    localparam int unsigned NUM_ENTRIES = 32;
    localparam int unsigned ADDR_W      = 5;
    localparam int unsigned CNT_W       = ADDR_W + 1;

    typedef logic [ADDR_W-1:0] address_t;

    // Opcode encodings; the remaining 4-bit codes are undefined.
    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    typedef struct packed {
        logic        [3:0]  opc;
        logic signed [31:0] op_a;
        logic signed [31:0] op_b;
        logic signed [63:0] result;
    } instruction_t;

endpackage

interface instr_reader_if;
    import instr_reader_pkg::*;

    logic         out_valid;
    logic         out_ready;
    instruction_t out_word;
    address_t     out_addr;
    logic         mismatch;

    modport master (
        output out_valid,
        input  out_ready,
        output out_word,
        output out_addr,
        output mismatch
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_word,
        input  out_addr,
        input  mismatch
    );

endinterface

// File: rtl/instr_reader.sv
// instr_reader
// Sweeps a wrap-around window of the 32-entry instruction register through
// its asynchronous read port and streams each captured word out on a
// valid/ready handshake. One word per two cycles when the consumer is ready.
// Optional result checking is enabled by defining INSTR_READER_CHECK_EN.

module instr_reader
    import instr_reader_pkg::*;
(
    input  logic           clk,
    input  logic           reset_n,
    input  logic           start,
    input  address_t       first_addr,
    input  logic [5:0]     count,
    output address_t       read_pointer,
    input  instruction_t   instruction_word,
    instr_reader_if.master bus,
    output logic           busy,
    output logic           done,
    output logic [5:0]     err_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    address_t           ptr_q, ptr_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic               valid_q, valid_d;
    instruction_t       word_q, word_d;
    address_t           oaddr_q, oaddr_d;
    logic               mm_q, mm_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [5:0]         err_q, err_d;
    logic               mm_c;

`ifdef INSTR_READER_CHECK_EN
    // Recompute the result in 64-bit signed arithmetic and compare with the stored one
    function automatic logic check_word(input instruction_t w);
        logic signed [63:0] a;
        logic signed [63:0] b;
        logic signed [63:0] expv;
        logic               bad;
        a    = {{32{w.op_a[31]}}, w.op_a};
        b    = {{32{w.op_b[31]}}, w.op_b};
        expv = '0;
        bad  = 1'b0;
        case (w.opc)
            OPC_ZERO:  bad = (w.result != 64'sd0);
            OPC_PASSA: bad = (w.result != a);
            OPC_PASSB: bad = (w.result != b);
            OPC_ADD:   bad = (w.result != (a + b));
            OPC_SUB:   bad = (w.result != (a - b));
            OPC_MULT:  bad = (w.result != (a * b));
            OPC_DIV: begin
                if (b != 64'sd0) begin
                    expv = a / b;
                    bad  = (w.result != expv);
                end
            end
            OPC_MOD: begin
                if (b != 64'sd0) begin
                    expv = a % b;
                    bad  = (w.result != expv);
                end
            end
            default:   bad = 1'b1;
        endcase
        return bad;
    endfunction

    assign mm_c = check_word(instruction_word);
`else
    assign mm_c = 1'b0;
`endif

    // State and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
            word_q  <= '0;
            oaddr_q <= '0;
            mm_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            rem_q   <= rem_d;
            valid_q <= valid_d;
            word_q  <= word_d;
            oaddr_q <= oaddr_d;
            mm_q    <= mm_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Next-state and next-output logic; everything holds unless a state moves it
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        rem_d   = rem_q;
        valid_d = valid_q;
        word_d  = word_q;
        oaddr_d = oaddr_q;
        mm_d    = mm_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    ptr_d   = first_addr;
                    rem_d   = (count == 6'd0) ? CNT_W'(NUM_ENTRIES) : CNT_W'(count);
                    err_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            FETCH: begin
                word_d  = instruction_word;
                oaddr_d = ptr_q;
                mm_d    = mm_c;
                valid_d = 1'b1;
                state_d = PRESENT;
            end
            PRESENT: begin
                if (bus.out_ready) begin
                    valid_d = 1'b0;
                    rem_d   = rem_q - CNT_W'(1);
                    if (mm_q && (err_q != 6'd63)) begin
                        err_d = err_q + 6'd1;
                    end
                    // Pointer only advances when another fetch follows, so it
                    // keeps the last fetched address while idle.
                    if (rem_q != CNT_W'(1)) begin
                        ptr_d   = ptr_q + ADDR_W'(1);
                        state_d = FETCH;
                    end else begin
                        done_d  = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign read_pointer  = ptr_q;
    assign bus.out_valid = valid_q;
    assign bus.out_word  = word_q;
    assign bus.out_addr  = oaddr_q;
    assign bus.mismatch  = mm_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign err_count     = err_q;

endmodule

// File: tb/tb_instr_reader.sv
// tb_instr_reader
// Directed bench for instr_reader: a small instruction-register model feeds
// the read port, and each sweep is checked word by word against hand values.

module tb_instr_reader;
    import instr_reader_pkg::*;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         start;
    address_t     first_addr;
    logic [5:0]   count;
    address_t     read_pointer;
    instruction_t instruction_word;
    logic         busy;
    logic         done;
    logic [5:0]   err_count;

    instr_reader_if bus ();

    instruction_t mem    [NUM_ENTRIES];
    logic         exp_mm [NUM_ENTRIES];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    // Asynchronous read port of the instruction register model
    always_comb instruction_word = mem[read_pointer];

    instr_reader dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .first_addr       (first_addr),
        .count            (count),
        .read_pointer     (read_pointer),
        .instruction_word (instruction_word),
        .bus              (bus.master),
        .busy             (busy),
        .done             (done),
        .err_count        (err_count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic instruction_t mk(input logic [3:0] opc, input int a, input int b,
                                        input longint r);
        instruction_t w;
        w.opc    = opc;
        w.op_a   = a;
        w.op_b   = b;
        w.result = r;
        return w;
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rp"},    64'(read_pointer),  64'd0);
        chk({tag, "_valid"}, 64'(bus.out_valid), 64'd0);
        chk({tag, "_word"},  64'(bus.out_word.result), 64'd0);
        chk({tag, "_opc"},   64'(bus.out_word.opc),    64'd0);
        chk({tag, "_addr"},  64'(bus.out_addr),  64'd0);
        chk({tag, "_mm"},    64'(bus.mismatch),  64'd0);
        chk({tag, "_busy"},  64'(busy),          64'd0);
        chk({tag, "_done"},  64'(done),          64'd0);
        chk({tag, "_err"},   64'(err_count),     64'd0);
    endtask

    // One sweep: optional 5-cycle stall on word stall_idx, optional reset while
    // word abort_idx is presented, optional ignored start during word 0.
    task automatic sweep(input string tag, input int first, input int cnt,
                         input int stall_idx, input int abort_idx, input bit poke_start);
        int k;
        int a;
        int busy_cycles;
        int err_exp;
        k           = (cnt == 0) ? 32 : cnt;
        busy_cycles = 0;
        err_exp     = 0;
        @(negedge clk);
        start      = 1'b1;
        first_addr = 5'(first);
        count      = 6'(cnt);
        @(negedge clk);
        start = 1'b0;
        if (busy) busy_cycles++;
        chk({tag, "_fetch_rp"},   64'(read_pointer),  64'(first));
        chk({tag, "_fetch_busy"}, 64'(busy),          64'd1);
        chk({tag, "_fetch_vld"},  64'(bus.out_valid), 64'd0);
        chk({tag, "_fetch_err"},  64'(err_count),     64'd0);
        for (int i = 0; i < k; i++) begin
            a = (first + i) % 32;
            @(negedge clk);
            if (busy) busy_cycles++;
            chk({tag, "_vld"},  64'(bus.out_valid),        64'd1);
            chk({tag, "_addr"}, 64'(bus.out_addr),         64'(a));
            chk({tag, "_res"},  64'(bus.out_word.result),  64'(mem[a].result));
            chk({tag, "_opc"},  64'(bus.out_word.opc),     64'(mem[a].opc));
            chk({tag, "_mm"},   64'(bus.mismatch),         64'(exp_mm[a]));
            chk({tag, "_done_lo"}, 64'(done),              64'd0);
            if (exp_mm[a]) err_exp++;
            if (poke_start && i == 0) begin
                start      = 1'b1;
                first_addr = 5'd7;
                count      = 6'd1;
            end
            if (i == abort_idx) begin
                reset_n = 1'b0;
                #1;
                chk_reset_vals({tag, "_abort"});
                @(negedge clk);
                chk({tag, "_abort_done"}, 64'(done), 64'd0);
                chk({tag, "_abort_busy"}, 64'(busy), 64'd0);
                reset_n = 1'b1;
                return;
            end
            if (i == stall_idx) begin
                bus.out_ready = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    if (busy) busy_cycles++;
                    chk({tag, "_stall_vld"},  64'(bus.out_valid),       64'd1);
                    chk({tag, "_stall_addr"}, 64'(bus.out_addr),        64'(a));
                    chk({tag, "_stall_res"},  64'(bus.out_word.result), 64'(mem[a].result));
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
            start = 1'b0;
            if (busy) busy_cycles++;
            chk({tag, "_gap_vld"}, 64'(bus.out_valid), 64'd0);
            if (i < k - 1) begin
                chk({tag, "_gap_done"}, 64'(done), 64'd0);
                chk({tag, "_gap_busy"}, 64'(busy), 64'd1);
            end else begin
                chk({tag, "_done"}, 64'(done),      64'd1);
                chk({tag, "_err"},  64'(err_count), 64'(err_exp));
            end
        end
        @(negedge clk);
        chk({tag, "_end_busy"}, 64'(busy), 64'd0);
        chk({tag, "_end_done"}, 64'(done), 64'd0);
        chk({tag, "_end_rp"},   64'(read_pointer), 64'((first + k - 1) % 32));
        chk({tag, "_busy_cyc"}, 64'(busy_cycles),
            64'(2 * k + 1 + ((stall_idx >= 0) ? 5 : 0)));
    endtask

    initial begin
        bit chk_en;
`ifdef INSTR_READER_CHECK_EN
        chk_en = 1'b1;
`else
        chk_en = 1'b0;
`endif
        for (int i = 0; i < 32; i++) begin
            mem[i]    = mk(OPC_ZERO, 0, 0, 0);
            exp_mm[i] = 1'b0;
        end
        mem[0]  = mk(OPC_ADD,   5,  7,  12);
        mem[1]  = mk(OPC_SUB,   3,  9,  -6);
        mem[2]  = mk(OPC_MULT, -4,  6, -24);
        mem[3]  = mk(OPC_PASSB, 0, 11,  11);
        mem[10] = mk(OPC_ADD,   2,  2,   5);
        mem[11] = mk(OPC_DIV,   7,  0, 123);
        mem[12] = mk(4'hF,      1,  1,   2);
        mem[30] = mk(OPC_PASSA, -9, 4,  -9);
        mem[31] = mk(OPC_MOD,   -7, 2,  -1);
        exp_mm[10] = chk_en;
        exp_mm[12] = chk_en;

        reset_n       = 1'b0;
        start         = 1'b0;
        first_addr    = '0;
        count         = '0;
        bus.out_ready = 1'b1;
        #12;
        chk_reset_vals("reset");
        @(negedge clk);
        reset_n = 1'b1;

        sweep("basic",   0, 4, -1, -1, 1'b0);
        sweep("wrap",   30, 4, -1, -1, 1'b1);
        sweep("full",    5, 0, -1, -1, 1'b0);
        sweep("stall",   0, 4,  1, -1, 1'b0);
        sweep("check",  10, 3, -1, -1, 1'b0);
        sweep("abort",   0, 4, -1,  1, 1'b0);
        sweep("restart", 0, 4, -1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
